// File: rtl/clkdiv_ctrl.sv
// Programmable clock-division controller: config handshake, start/stop sequencing,
// tick and square-wave enables, burst-limited tick counting.
module clkdiv_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_burst,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             clk_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tick_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] div_reg, div_nx;
  logic [WIDTH-1:0] phase, phase_nx, phase_inc;
  logic [CNT_W-1:0] burst_reg, burst_nx;
  logic [CNT_W-1:0] cnt_nx, cnt_inc;
  logic             tick_nx, clk_out_nx, done_nx;
  logic             phase_hit;

  // Next-state and next-output logic; every register gets its next value here.
  always_comb begin
    state_nx   = state;
    div_nx     = div_reg;
    burst_nx   = burst_reg;
    phase_nx   = phase;
    cnt_nx     = tick_cnt;
    tick_nx    = 1'b0;
    done_nx    = 1'b0;
    clk_out_nx = clk_out;
    phase_inc  = phase + WIDTH'(1);
    cnt_inc    = tick_cnt + CNT_W'(1);
    phase_hit  = (phase_inc == div_reg);

    case (state)
      IDLE: begin
        if (cfg_valid) begin
          div_nx   = (cfg_div == '0) ? WIDTH'(1) : cfg_div;
          burst_nx = cfg_burst;
        end
        if (start && !stop) begin
          state_nx   = RUN;
          phase_nx   = '0;
          cnt_nx     = '0;
          clk_out_nx = 1'b0;
        end
      end
      RUN: begin
        // stop takes priority over a tick falling due on the same edge
        if (stop) begin
          state_nx   = IDLE;
          clk_out_nx = 1'b0;
        end else if (phase_hit) begin
          phase_nx   = '0;
          tick_nx    = 1'b1;
          cnt_nx     = cnt_inc;
          clk_out_nx = !clk_out;
          if ((burst_reg != '0) && (cnt_inc == burst_reg)) begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end
        end else begin
          phase_nx = phase_inc;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      div_reg   <= WIDTH'(1);
      burst_reg <= '0;
      phase     <= '0;
      tick      <= 1'b0;
      clk_out   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tick_cnt  <= '0;
      cfg_ready <= 1'b1;
    end else begin
      state     <= state_nx;
      div_reg   <= div_nx;
      burst_reg <= burst_nx;
      phase     <= phase_nx;
      tick      <= tick_nx;
      clk_out   <= clk_out_nx;
      busy      <= (state_nx == RUN);
      done      <= done_nx;
      tick_cnt  <= cnt_nx;
      cfg_ready <= (state_nx == IDLE);
    end
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Scoreboard bench for clkdiv_ctrl: each run's tick schedule is derived arithmetically
// and queued; a monitor pops one entry per observed tick.
module tb_clkdiv_ctrl;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MOD = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_div = '0;
  logic [CNT_W-1:0] cfg_burst = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             tick, clk_out, busy, done;
  logic [CNT_W-1:0] tick_cnt;

  always #5 clk = ~clk;

  clkdiv_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_burst(cfg_burst), .start(start), .stop(stop),
    .tick(tick), .clk_out(clk_out), .busy(busy), .done(done), .tick_cnt(tick_cnt)
  );

  typedef struct {
    int cyc;
    int cnt;
    bit clk_o;
    bit done_o;
    bit busy_o;
  } ev_t;

  ev_t sb[$];
  int  compared = 0;
  int  failed = 0;
  int  cyc = 0;
  int  mdl_div = 1;
  int  mdl_burst = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pops one expected tick per observed tick; done must never appear without a tick.
  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (tick) begin
          if (sb.size() == 0) begin
            compared++;
            failed++;
            $display("FAIL unexpected_tick: tick seen with empty queue (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            chk("tick_cycle", cyc, e.cyc);
            chk("tick_cnt", int'(tick_cnt), e.cnt);
            chk("tick_clk_out", int'(clk_out), int'(e.clk_o));
            chk("tick_done", int'(done), int'(e.done_o));
            chk("tick_busy", int'(busy), int'(e.busy_o));
          end
        end else begin
          chk("done_without_tick", int'(done), 0);
        end
      end
    end
  endtask

  task automatic do_cfg(input int d, input int b);
    cfg_valid = 1'b1;
    cfg_div   = WIDTH'(d);
    cfg_burst = CNT_W'(b);
    chk("cfg_ready_idle", int'(cfg_ready), 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    mdl_div   = (d == 0) ? 1 : d;
    mdl_burst = b;
  endtask

  // One run: s = stop edge offset from E0 (0 = none), optional config offer held during RUN.
  task automatic run(input int s, input bit hold, input int hd, input int hb);
    int  n, b, e0, k, t;
    bit  stopped;
    ev_t e;
    n  = mdl_div;
    b  = mdl_burst;
    start = 1'b1;
    e0 = cyc + 1;
    k  = 0;
    while ((b == 0 || k < b) && (s == 0 || (k + 1) * n < s) && k < 1000) begin
      k++;
      e.cyc    = e0 + k * n;
      e.cnt    = k % CNT_MOD;
      e.clk_o  = (k % 2 == 1);
      e.done_o = (b != 0 && k == b);
      e.busy_o = !e.done_o;
      sb.push_back(e);
    end
    stopped = (s != 0) && (b == 0 || s <= b * n);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("cfg_ready_in_run", int'(cfg_ready), 0);
    if (hold) begin
      cfg_valid = 1'b1;
      cfg_div   = WIDTH'(hd);
      cfg_burst = CNT_W'(hb);
    end
    if (s != 0) begin
      while (cyc < e0 + s - 1) begin
        @(posedge clk); #1;
      end
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
    end else begin
      t = 0;
      while (busy && t < 5000) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 5000) begin
        compared++;
        failed++;
        $display("FAIL run_timeout: busy still %0d after %0d cycles, expected 0", busy, t);
      end
    end
    @(posedge clk); #1;
    if (hold) begin
      cfg_valid = 1'b0;
      mdl_div   = (hd == 0) ? 1 : hd;
      mdl_burst = hb;
    end
    chk("end_busy", int'(busy), 0);
    chk("end_cfg_ready", int'(cfg_ready), 1);
    chk("end_tick", int'(tick), 0);
    chk("end_done", int'(done), 0);
    chk("end_tick_cnt", int'(tick_cnt), k % CNT_MOD);
    chk("end_clk_out", int'(clk_out), stopped ? 0 : (k % 2));
    chk("queue_drained", sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tick"}, int'(tick), 0);
    chk({tag, "_clk_out"}, int'(clk_out), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_tick_cnt"}, int'(tick_cnt), 0);
    chk({tag, "_cfg_ready"}, int'(cfg_ready), 1);
  endtask

  initial begin
    int  e0;
    int  s;
    bit  hold;
    bit  pend;
    int  hd, hb;
    ev_t e;

    rst = 1'b1;
    #1 rst = 1'b0;
    #1 check_reset_outputs("por");
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;

    // div=4 burst=3
    do_cfg(4, 3);
    run(0, 1'b0, 0, 0);
    // div=0 treated as 1, free-run
    do_cfg(0, 0);
    run(10, 1'b0, 0, 0);
    // div=1, 17 ticks wrap the 4-bit counter to 1
    do_cfg(1, 0);
    run(18, 1'b0, 0, 0);
    // div=5, stop at E0+7
    do_cfg(5, 0);
    run(7, 1'b0, 0, 0);
    // div=3, stop exactly on a due tick
    do_cfg(3, 0);
    run(6, 1'b0, 0, 0);
    // config offered during RUN is held off, then used by the following run
    do_cfg(2, 2);
    run(0, 1'b1, 6, 1);
    run(0, 1'b0, 0, 0);

    // start together with stop in IDLE stays IDLE
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_idle_busy", int'(busy), 0);
    chk("start_stop_idle_ready", int'(cfg_ready), 1);

    // asynchronous reset mid-run
    do_cfg(3, 0);
    start = 1'b1;
    e0 = cyc + 1;
    e.cyc = e0 + 3; e.cnt = 1; e.clk_o = 1'b1; e.done_o = 1'b0; e.busy_o = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_tick_cnt", int'(tick_cnt), 1);
    chk("pre_reset_clk_out", int'(clk_out), 1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    sb.delete();
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_busy", int'(busy), 0);
    mdl_div   = 1;
    mdl_burst = 0;
    run(5, 1'b0, 0, 0);

    // randomized runs
    pend = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (!pend) do_cfg(int'($urandom_range(0, 9)), int'($urandom_range(0, 6)));
      if (mdl_burst == 0) s = int'($urandom_range(1, 40));
      else if ($urandom_range(0, 2) == 0) s = int'($urandom_range(1, mdl_burst * mdl_div + 3));
      else s = 0;
      hold = ($urandom_range(0, 3) == 0);
      hd   = int'($urandom_range(0, 9));
      hb   = int'($urandom_range(0, 6));
      run(s, hold, hd, hb);
      pend = hold;
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
